// File: rtl/peak_sorter_pkg.sv
// Package for the peak sorter.
// Holds the default parameter constants, the packed table-entry type, the
// slot-mux select encodings, and the signed modular window test that the
// code/frequency merge check uses.
package peak_sorter_pkg;

  localparam int PS_PEAK_NUM = 4;
  localparam int PS_AMP_W    = 8;
  localparam int PS_EXP_W    = 4;
  localparam int PS_COR_W    = 15;
  localparam int PS_FREQ_W   = 9;
  localparam int PS_COR_WIN  = 1;
  localparam int PS_FREQ_WIN = 1;

  // One table entry at the default widths.
  typedef struct packed {
    logic                   vld;
    logic [PS_AMP_W-1:0]    amp;
    logic [PS_COR_W-1:0]    cor;
    logic [PS_FREQ_W-1:0]   freq;
  } peak_entry_t;

  // Slot-mux selects for the insertion network.
  localparam logic [1:0] SEL_KEEP = 2'd0;
  localparam logic [1:0] SEL_PREV = 2'd1;
  localparam logic [1:0] SEL_NEW  = 2'd2;

  // True when (a - b) mod 2^w, read as a signed w-bit value, lies in
  // [-win, +win]. Wrap-around at 0 / full scale falls out of the modulo.
  function automatic logic win_match(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input int          w,
                                     input int          win);
    logic [32:0] full;
    logic [32:0] diff;
    logic [32:0] mag;
    full = 33'd1 << w;
    diff = ({1'b0, a} - {1'b0, b}) & (full - 33'd1);
    if (((diff >> (w - 1)) & 33'd1) != 33'd0) mag = full - diff;
    else                                       mag = diff;
    return mag <= 33'(win);
  endfunction

endpackage

// File: rtl/peak_sorter_n_bfp_rshift.sv
// bfp_rshift: saturating right shift of a block-floating-point mantissa.
// Ports:
//   amp_in  - AMP_W mantissa
//   sh_amt  - EXP_W shift amount (exponent difference)
//   amp_out - amp_in >> sh_amt, forced to 0 when sh_amt >= AMP_W
module bfp_rshift #(
  parameter int AMP_W = 8,
  parameter int EXP_W = 4
) (
  input  logic [AMP_W-1:0] amp_in,
  input  logic [EXP_W-1:0] sh_amt,
  output logic [AMP_W-1:0] amp_out
);

  always_comb begin
    if (32'(sh_amt) >= 32'(AMP_W)) amp_out = '0;
    else                           amp_out = amp_in >> sh_amt;
  end

endmodule

// File: rtl/peak_sorter_n.sv
// peak_sorter_n: keeps the PEAK_NUM largest block-floating-point peaks in
// descending order, merging results that land within a code/frequency window
// of an existing peak.
// Ports:
//   clk, rst_b        - clock, asynchronous active-low reset
//   clear             - synchronous clear of table, exponent and stage 1
//   in_valid          - sample strobe (amp/exp/cor/freq)
//   peak_amp/cor/freq - packed table, entry i at [i*W +: W], entry 0 largest
//   peak_vld          - per-entry valid flags
//   peak_exp          - exponent shared by every table entry
//   busy              - stage 1 holds a sample not yet folded into the table
// Pipeline: stage 1 registers the sample; stage 2 aligns exponents, finds the
// merge candidate and rank, and writes the whole table in one edge, so the
// next sample always sees the fully updated table.
module peak_sorter_n
  import peak_sorter_pkg::*;
#(
  parameter int PEAK_NUM = PS_PEAK_NUM,
  parameter int AMP_W    = PS_AMP_W,
  parameter int EXP_W    = PS_EXP_W,
  parameter int COR_W    = PS_COR_W,
  parameter int FREQ_W   = PS_FREQ_W,
  parameter int COR_WIN  = PS_COR_WIN,
  parameter int FREQ_WIN = PS_FREQ_WIN
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [AMP_W-1:0]           in_amp,
  input  logic [EXP_W-1:0]           in_exp,
  input  logic [COR_W-1:0]           in_cor,
  input  logic [FREQ_W-1:0]          in_freq,
  output logic [PEAK_NUM*AMP_W-1:0]  peak_amp,
  output logic [PEAK_NUM*COR_W-1:0]  peak_cor,
  output logic [PEAK_NUM*FREQ_W-1:0] peak_freq,
  output logic [PEAK_NUM-1:0]        peak_vld,
  output logic [EXP_W-1:0]           peak_exp,
  output logic                       busy
);

  // Wide enough to hold a rank equal to PEAK_NUM ("below every entry").
  localparam int IDX_W = $clog2(PEAK_NUM + 1);

  // Stage 1 registers
  logic              s1_vld_q, s1_vld_d;
  logic [AMP_W-1:0]  s1_amp_q, s1_amp_d;
  logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
  logic [COR_W-1:0]  s1_cor_q, s1_cor_d;
  logic [FREQ_W-1:0] s1_freq_q, s1_freq_d;

  // Peak table
  logic [AMP_W-1:0]  amp_q  [PEAK_NUM];
  logic [AMP_W-1:0]  amp_d  [PEAK_NUM];
  logic [COR_W-1:0]  cor_q  [PEAK_NUM];
  logic [COR_W-1:0]  cor_d  [PEAK_NUM];
  logic [FREQ_W-1:0] freq_q [PEAK_NUM];
  logic [FREQ_W-1:0] freq_d [PEAK_NUM];
  logic [PEAK_NUM-1:0] vld_q, vld_d;
  logic [EXP_W-1:0]  exp_q, exp_d;

  // Stage 2 combinational signals
  logic              up_exp;
  logic [EXP_W-1:0]  tbl_sh, in_sh;
  logic [AMP_W-1:0]  in_aligned;
  logic [AMP_W-1:0]  tbl_amp [PEAK_NUM];
  logic [PEAK_NUM-1:0] hit;
  logic              match, drop;
  logic [IDX_W-1:0]  m_idx, k_idx, hi_idx;
  logic [AMP_W-1:0]  m_amp;
  logic [AMP_W-1:0]  slot_amp  [PEAK_NUM];
  logic [COR_W-1:0]  slot_cor  [PEAK_NUM];
  logic [FREQ_W-1:0] slot_freq [PEAK_NUM];
  logic [PEAK_NUM-1:0] slot_vld;

  // ---------------------------------------------------------------- stage 1
  always_comb begin
    // clear kills a same-cycle strobe; data registers just follow in_valid.
    s1_vld_d  = in_valid && !clear;
    s1_amp_d  = in_valid ? in_amp  : s1_amp_q;
    s1_exp_d  = in_valid ? in_exp  : s1_exp_q;
    s1_cor_d  = in_valid ? in_cor  : s1_cor_q;
    s1_freq_d = in_valid ? in_freq : s1_freq_q;
  end

  // ------------------------------------------------------ exponent alignment
  // Whichever side has the smaller exponent is shifted down; the other side
  // is used as-is.
  always_comb begin
    up_exp = s1_exp_q > exp_q;
    tbl_sh = '0;
    in_sh  = '0;
    if (up_exp) tbl_sh = s1_exp_q - exp_q;
    else        in_sh  = exp_q - s1_exp_q;
  end

  bfp_rshift #(.AMP_W(AMP_W), .EXP_W(EXP_W)) u_in_shift (
    .amp_in  (s1_amp_q),
    .sh_amt  (in_sh),
    .amp_out (in_aligned)
  );

  for (genvar i = 0; i < PEAK_NUM; i++) begin : g_tbl
    bfp_rshift #(.AMP_W(AMP_W), .EXP_W(EXP_W)) u_tbl_shift (
      .amp_in  (amp_q[i]),
      .sh_amt  (tbl_sh),
      .amp_out (tbl_amp[i])
    );

    assign hit[i] = vld_q[i]
                 && win_match(32'(s1_cor_q),  32'(cor_q[i]),  COR_W,  COR_WIN)
                 && win_match(32'(s1_freq_q), 32'(freq_q[i]), FREQ_W, FREQ_WIN);
  end

  // ------------------------------------------------------- match and rank
  always_comb begin
    match = 1'b0;
    m_idx = '0;
    m_amp = '0;
    k_idx = '0;
    // Descending scan so the lowest matching index wins.
    for (int i = PEAK_NUM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        match = 1'b1;
        m_idx = IDX_W'(i);
        m_amp = tbl_amp[i];
      end
    end
    // Entries equal to the new amplitude count as above it (older wins ties).
    for (int i = 0; i < PEAK_NUM; i++) begin
      if (vld_q[i] && (tbl_amp[i] >= in_aligned)) k_idx = k_idx + IDX_W'(1);
    end
    // hi_idx is the last slot that shifts down: the merged slot is consumed
    // in place, otherwise the bottom entry falls off.
    if (match) begin
      drop   = m_amp >= in_aligned;
      hi_idx = m_idx;
    end else begin
      drop   = k_idx == IDX_W'(PEAK_NUM);
      hi_idx = IDX_W'(PEAK_NUM - 1);
    end
  end

  // ---------------------------------------------------- insertion network
  // Slot k takes the new sample, slots k+1..hi take their upper neighbour,
  // all others keep their (aligned) contents. Slot 0 never takes PREV.
  for (genvar i = 0; i < PEAK_NUM; i++) begin : g_slot
    localparam int PI = (i == 0) ? 0 : i - 1;
    logic [1:0] sel;

    always_comb begin
      sel = SEL_KEEP;
      if (!drop) begin
        if (IDX_W'(i) == k_idx)                            sel = SEL_NEW;
        else if ((IDX_W'(i) > k_idx) && (IDX_W'(i) <= hi_idx)) sel = SEL_PREV;
      end
    end

    assign slot_amp[i]  = (sel == SEL_NEW)  ? in_aligned :
                          (sel == SEL_PREV) ? tbl_amp[PI] : tbl_amp[i];
    assign slot_cor[i]  = (sel == SEL_NEW)  ? s1_cor_q :
                          (sel == SEL_PREV) ? cor_q[PI] : cor_q[i];
    assign slot_freq[i] = (sel == SEL_NEW)  ? s1_freq_q :
                          (sel == SEL_PREV) ? freq_q[PI] : freq_q[i];
    assign slot_vld[i]  = (sel == SEL_NEW)  ? 1'b1 :
                          (sel == SEL_PREV) ? vld_q[PI] : vld_q[i];
  end

  // ---------------------------------------------------- table next state
  always_comb begin
    for (int i = 0; i < PEAK_NUM; i++) begin
      amp_d[i]  = amp_q[i];
      cor_d[i]  = cor_q[i];
      freq_d[i] = freq_q[i];
    end
    vld_d = vld_q;
    exp_d = exp_q;
    if (clear) begin
      for (int i = 0; i < PEAK_NUM; i++) begin
        amp_d[i]  = '0;
        cor_d[i]  = '0;
        freq_d[i] = '0;
      end
      vld_d = '0;
      exp_d = '0;
    end else if (s1_vld_q) begin
      // Even a dropped sample applies the alignment shift (KEEP slots carry
      // the shifted amplitudes).
      for (int i = 0; i < PEAK_NUM; i++) begin
        amp_d[i]  = slot_amp[i];
        cor_d[i]  = slot_cor[i];
        freq_d[i] = slot_freq[i];
      end
      vld_d = slot_vld;
      if (up_exp) exp_d = s1_exp_q;
    end
  end

  // ---------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_vld_q  <= 1'b0;
      s1_amp_q  <= '0;
      s1_exp_q  <= '0;
      s1_cor_q  <= '0;
      s1_freq_q <= '0;
      for (int i = 0; i < PEAK_NUM; i++) begin
        amp_q[i]  <= '0;
        cor_q[i]  <= '0;
        freq_q[i] <= '0;
      end
      vld_q <= '0;
      exp_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_amp_q  <= s1_amp_d;
      s1_exp_q  <= s1_exp_d;
      s1_cor_q  <= s1_cor_d;
      s1_freq_q <= s1_freq_d;
      for (int i = 0; i < PEAK_NUM; i++) begin
        amp_q[i]  <= amp_d[i];
        cor_q[i]  <= cor_d[i];
        freq_q[i] <= freq_d[i];
      end
      vld_q <= vld_d;
      exp_q <= exp_d;
    end
  end

  // ------------------------------------------------------------ outputs
  for (genvar i = 0; i < PEAK_NUM; i++) begin : g_out
    assign peak_amp[i*AMP_W +: AMP_W]    = amp_q[i];
    assign peak_cor[i*COR_W +: COR_W]    = cor_q[i];
    assign peak_freq[i*FREQ_W +: FREQ_W] = freq_q[i];
  end
  assign peak_vld = vld_q;
  assign peak_exp = exp_q;
  assign busy     = s1_vld_q;

endmodule

// File: tb/tb_peak_sorter_n.sv
// Testbench for peak_sorter_n: directed cases plus randomized back-to-back
// bursts, checked against a queue-based reference model of the peak table.
module tb_peak_sorter_n;
  import peak_sorter_pkg::*;

  localparam int PN  = PS_PEAK_NUM;
  localparam int AW  = PS_AMP_W;
  localparam int EW  = PS_EXP_W;
  localparam int CW  = PS_COR_W;
  localparam int FW  = PS_FREQ_W;
  localparam int CWN = PS_COR_WIN;
  localparam int FWN = PS_FREQ_WIN;

  logic             clk;
  logic             rst_b;
  logic             clear;
  logic             in_valid;
  logic [AW-1:0]    in_amp;
  logic [EW-1:0]    in_exp;
  logic [CW-1:0]    in_cor;
  logic [FW-1:0]    in_freq;
  logic [PN*AW-1:0] peak_amp;
  logic [PN*CW-1:0] peak_cor;
  logic [PN*FW-1:0] peak_freq;
  logic [PN-1:0]    peak_vld;
  logic [EW-1:0]    peak_exp;
  logic             busy;

  peak_sorter_n #(
    .PEAK_NUM(PN), .AMP_W(AW), .EXP_W(EW), .COR_W(CW), .FREQ_W(FW),
    .COR_WIN(CWN), .FREQ_WIN(FWN)
  ) dut (
    .clk(clk), .rst_b(rst_b), .clear(clear), .in_valid(in_valid),
    .in_amp(in_amp), .in_exp(in_exp), .in_cor(in_cor), .in_freq(in_freq),
    .peak_amp(peak_amp), .peak_cor(peak_cor), .peak_freq(peak_freq),
    .peak_vld(peak_vld), .peak_exp(peak_exp), .busy(busy)
  );

  // ------------------------------------------------ clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ------------------------------------------------ reference model
  // Table held as a queue of valid entries in descending order.
  peak_entry_t mtbl[$];
  int          mexp;

  function automatic int sdiff(input int a, input int b, input int w);
    int d;
    d = (a - b) & ((1 << w) - 1);
    if (d >= (1 << (w - 1))) d = d - (1 << w);
    return d;
  endfunction

  task automatic model_clear();
    mtbl.delete();
    mexp = 0;
  endtask

  task automatic model_apply(input int amp, input int e, input int cor, input int freq);
    int na;
    int m;
    int k;
    int dc;
    int df;
    peak_entry_t ne;
    na = amp;
    if (e > mexp) begin
      foreach (mtbl[i]) mtbl[i].amp = AW'(int'(mtbl[i].amp) >> (e - mexp));
      mexp = e;
    end else begin
      na = amp >> (mexp - e);
    end
    m = -1;
    foreach (mtbl[i]) begin
      dc = sdiff(cor, int'(mtbl[i].cor), CW);
      df = sdiff(freq, int'(mtbl[i].freq), FW);
      if (m < 0 && dc >= -CWN && dc <= CWN && df >= -FWN && df <= FWN) m = i;
    end
    k = 0;
    foreach (mtbl[i]) if (int'(mtbl[i].amp) >= na) k++;
    ne.vld  = 1'b1;
    ne.amp  = AW'(na);
    ne.cor  = CW'(cor);
    ne.freq = FW'(freq);
    if (m >= 0) begin
      if (int'(mtbl[m].amp) >= na) return;
      mtbl.delete(m);
    end else if (k >= PN) begin
      return;
    end
    if (k >= mtbl.size()) mtbl.push_back(ne);
    else                  mtbl.insert(k, ne);
    while (mtbl.size() > PN) void'(mtbl.pop_back());
  endtask

  task automatic check_table(input string tag);
    logic [PN*AW-1:0] ea;
    logic [PN*CW-1:0] ec;
    logic [PN*FW-1:0] ef;
    logic [PN-1:0]    ev;
    ea = '0; ec = '0; ef = '0; ev = '0;
    foreach (mtbl[i]) begin
      ea[i*AW +: AW] = mtbl[i].amp;
      ec[i*CW +: CW] = mtbl[i].cor;
      ef[i*FW +: FW] = mtbl[i].freq;
      ev[i]          = 1'b1;
    end
    exp_q.push_back(64'(ea));
    exp_q.push_back(64'(ec));
    exp_q.push_back(64'(ef));
    exp_q.push_back(64'(ev));
    exp_q.push_back(64'(mexp));
    check({tag, "_amp"},  64'(peak_amp),  exp_q.pop_front());
    check({tag, "_cor"},  64'(peak_cor),  exp_q.pop_front());
    check({tag, "_freq"}, 64'(peak_freq), exp_q.pop_front());
    check({tag, "_vld"},  64'(peak_vld),  exp_q.pop_front());
    check({tag, "_exp"},  64'(peak_exp),  exp_q.pop_front());
  endtask

  // ------------------------------------------------ driver tasks
  // All tasks start and end 1 time unit after a rising edge.
  task automatic drive_cycle(input logic v, input logic clr, input int amp,
                             input int e, input int cor, input int freq);
    in_valid = v;
    clear    = clr;
    in_amp   = AW'(amp);
    in_exp   = EW'(e);
    in_cor   = CW'(cor);
    in_freq  = FW'(freq);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    if (clr)    model_clear();
    else if (v) model_apply(amp, e, cor, freq);
  endtask

  task automatic send(input int amp, input int e, input int cor, input int freq);
    drive_cycle(1'b1, 1'b0, amp, e, cor, freq);
  endtask

  task automatic do_clear();
    drive_cycle(1'b0, 1'b1, 0, 0, 0, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // ------------------------------------------------ stimulus
  initial begin
    rst_b    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_amp   = '0;
    in_exp   = '0;
    in_cor   = '0;
    in_freq  = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_amp",  64'(peak_amp),  64'd0);
    check("rst_cor",  64'(peak_cor),  64'd0);
    check("rst_freq", 64'(peak_freq), 64'd0);
    check("rst_vld",  64'(peak_vld),  64'd0);
    check("rst_exp",  64'(peak_exp),  64'd0);
    check("rst_busy", 64'(busy),      64'd0);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Sorted fill
    send(50, 2, 100, 10);
    send(80, 2, 500, 20);
    send(30, 2, 900, 30);
    send(60, 2, 1300, 40);
    wait_idle("fill");
    check_table("fill");
    check("fill_const_amp", 64'(peak_amp), 64'h1E32_3C50);

    // Smaller neighbour dropped, larger neighbour merged into slot 0
    send(70, 2, 501, 21);
    wait_idle("mdrop");
    check_table("mdrop");
    send(90, 2, 499, 19);
    wait_idle("mrep");
    check_table("mrep");
    check("mrep_cor0", 64'(peak_cor[CW-1:0]), 64'd499);

    // Exponent increase shifts table, bottom entry pushed out
    do_clear();
    send(50, 2, 100, 10);
    send(80, 2, 500, 20);
    send(30, 2, 900, 30);
    send(60, 2, 1300, 40);
    send(40, 5, 7000, 100);
    wait_idle("exp");
    check_table("exp");
    check("exp_const_amp", 64'(peak_amp), 64'h0607_0A28);
    check("exp_const_exp", 64'(peak_exp), 64'd5);

    // Code wrap-around merge
    do_clear();
    send(20, 1, 0, 5);
    send(50, 1, 32767, 6);
    wait_idle("wrap");
    check_table("wrap");
    check("wrap_vld", 64'(peak_vld), 64'd1);

    // Randomized back-to-back bursts around the wrap point
    for (int r = 0; r < 6; r++) begin
      do_clear();
      for (int s = 0; s < 16; s++) begin
        int e;
        e = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 12) : $urandom_range(0, 3);
        send($urandom_range(0, 255), e,
             ($urandom_range(0, 8) + 32764) % 32768,
             ($urandom_range(0, 6) + 510) % 512);
      end
      wait_idle($sformatf("rnd%0d", r));
      check_table($sformatf("rnd%0d", r));
    end

    // clear together with in_valid
    send(100, 1, 10, 10);
    wait_idle("pre_clr");
    drive_cycle(1'b1, 1'b1, 77, 1, 20, 20);
    @(posedge clk);
    #1;
    check_table("clr_iv");
    check("clr_iv_busy", 64'(busy), 64'd0);

    // clear while stage 1 holds a sample
    send(100, 1, 10, 10);
    check("clr_s1_busy_pre", 64'(busy), 64'd1);
    do_clear();
    @(posedge clk);
    #1;
    check_table("clr_s1");
    check("clr_s1_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
